// File: rtl/alu_pkg.sv
// Shared types for the ALU result path: status flag layout and the
// state encoding of the 2-entry skid buffer that carries result beats.
package alu_pkg;

  // Status flags travel as one packed nibble {V,N,Z,S}; v is the MSB.
  typedef struct packed {
    logic v;  // signed overflow reported by the subtractor
    logic n;  // MSB of the truncated difference
    logic z;  // truncated difference is zero
    logic s;  // true sign, taken from the extra result bit
  } flags_t;

  // Bit positions of each flag inside the packed nibble.
  localparam int FLAG_V = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_S = 0;

  // Occupancy of the skid buffer.
  typedef enum logic [1:0] {
    SK_EMPTY = 2'd0,  // nothing held
    SK_ONE   = 2'd1,  // main register holds the output beat
    SK_FULL  = 2'd2   // main and skid registers both hold beats
  } skid_state_t;

endpackage

// File: rtl/sub_result_stage_if.sv
// Result-path bus between the subtractor, this stage and the ALU result bus.
//
// Handshake: on both channels a beat transfers on a rising clock edge where
// valid && ready. The producer holds valid and its data stable until the
// transfer; ready may toggle freely and never depends combinationally on
// valid. in_* is the upstream channel, out_* the downstream channel.
interface sub_result_stage_if #(
  parameter int SIZE = 8
);
  logic            in_valid;
  logic            in_ready;
  logic [SIZE:0]   in_result;
  logic            in_overflow;
  logic            out_valid;
  logic            out_ready;
  logic [SIZE-1:0] out_result;
  logic [3:0]      out_flags;

  // Environment side: drives the subtractor result and the consumer ready.
  modport master (
    output in_valid, in_result, in_overflow, out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );

  // Stage side.
  modport slave (
    input  in_valid, in_result, in_overflow, out_ready,
    output in_ready, out_valid, out_result, out_flags
  );
endinterface

// File: rtl/skid_buffer.sv
// Generic 2-entry valid/ready buffer. in_ready and out_valid both come
// straight from registers, so there is no combinational path from
// out_ready to in_ready. Data is FIFO ordered and out_data is held stable
// while out_valid && !out_ready.
module skid_buffer
  import alu_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output skid_state_t      state
);

  skid_state_t      state_r;
  logic [WIDTH-1:0] main_r;
  logic [WIDTH-1:0] skid_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             accept;
  logic             emit;

  assign accept = in_valid && in_ready_r;
  assign emit   = out_valid_r && out_ready;

  // Occupancy FSM; ready/valid are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= SK_EMPTY;
      main_r      <= '0;
      skid_r      <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        SK_EMPTY: begin
          if (accept) begin
            main_r      <= in_data;
            out_valid_r <= 1'b1;
            state_r     <= SK_ONE;
          end
        end
        SK_ONE: begin
          if (accept && !emit) begin
            // Consumer stalled: park the new beat behind the held one.
            skid_r     <= in_data;
            in_ready_r <= 1'b0;
            state_r    <= SK_FULL;
          end else if (!accept && emit) begin
            out_valid_r <= 1'b0;
            state_r     <= SK_EMPTY;
          end else if (accept && emit) begin
            // Streaming at full rate: replace the beat just taken.
            main_r <= in_data;
          end
        end
        SK_FULL: begin
          // in_ready is low here, so only an emit can change anything.
          if (emit) begin
            main_r     <= skid_r;
            in_ready_r <= 1'b1;
            state_r    <= SK_ONE;
          end
        end
        default: begin
          state_r     <= SK_EMPTY;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = main_r;
  assign state     = state_r;

endmodule

// File: rtl/sub_result_stage.sv
// Registered output stage behind the combinational subtractor. Derives
// {V,N,Z,S} from the sign-extended difference, buffers flags and the
// truncated difference through a skid buffer, and keeps a sticky overflow
// flag plus a saturating count of accepted overflow beats.
module sub_result_stage
  import alu_pkg::*;
#(
  parameter int SIZE      = 8,
  parameter int OVF_CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sub_result_stage_if.slave    bus,
  input  logic                 clr_sticky,
  output logic                 sticky_ovf,
  output logic [OVF_CNT_W-1:0] ovf_count,
  output skid_state_t          skid_state
);

  localparam int WIDTH = $bits(flags_t) + SIZE;
  localparam logic [OVF_CNT_W-1:0] CNT_MAX = {OVF_CNT_W{1'b1}};
  localparam logic [OVF_CNT_W-1:0] CNT_ONE = {{(OVF_CNT_W-1){1'b0}}, 1'b1};

  flags_t           in_flags;
  flags_t           out_flags_s;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] out_data;
  logic             in_ready_s;
  logic             out_valid_s;
  logic             ovf_accept;

  // Flags come from the incoming result so they register with the data.
  always_comb begin
    in_flags   = '0;
    in_flags.v = bus.in_overflow;
    in_flags.n = bus.in_result[SIZE-1];
    in_flags.z = (bus.in_result[SIZE-1:0] == '0);
    in_flags.s = bus.in_result[SIZE];
  end

  assign in_data = {in_flags, bus.in_result[SIZE-1:0]};

  skid_buffer #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .in_ready  (in_ready_s),
    .in_data   (in_data),
    .out_valid (out_valid_s),
    .out_ready (bus.out_ready),
    .out_data  (out_data),
    .state     (skid_state)
  );

  assign out_flags_s    = flags_t'(out_data[WIDTH-1:SIZE]);
  assign bus.in_ready   = in_ready_s;
  assign bus.out_valid  = out_valid_s;
  assign bus.out_result = out_data[SIZE-1:0];
  assign bus.out_flags  = {out_flags_s.v, out_flags_s.n, out_flags_s.z, out_flags_s.s};

  // Overflow bookkeeping counts accepted beats, not emitted ones.
  assign ovf_accept = bus.in_valid && in_ready_s && bus.in_overflow;

  // Sticky flag and saturating counter; a same-cycle overflow accept beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_ovf <= 1'b0;
      ovf_count  <= '0;
    end else if (ovf_accept) begin
      sticky_ovf <= 1'b1;
      if (clr_sticky) begin
        ovf_count <= CNT_ONE;
      end else if (ovf_count != CNT_MAX) begin
        ovf_count <= ovf_count + CNT_ONE;
      end
    end else if (clr_sticky) begin
      sticky_ovf <= 1'b0;
      ovf_count  <= '0;
    end
  end

endmodule

// File: tb/tb_sub_result_stage.sv
// Directed bench for sub_result_stage (SIZE=8, OVF_CNT_W=4) followed by a
// randomized valid/ready stretch checked against an expected queue.
module tb_sub_result_stage;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        clr_sticky;
  logic        sticky_ovf;
  logic [3:0]  ovf_count;
  skid_state_t skid_state;

  int n_pass  = 0;
  int n_total = 0;

  logic [11:0] exp_q[$];

  sub_result_stage_if #(.SIZE(8)) bus ();

  sub_result_stage #(
    .SIZE      (8),
    .OVF_CNT_W (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .clr_sticky (clr_sticky),
    .sticky_ovf (sticky_ovf),
    .ovf_count  (ovf_count),
    .skid_state (skid_state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [8:0] res, input logic ovf);
    bus.in_valid    = 1'b1;
    bus.in_result   = res;
    bus.in_overflow = ovf;
  endtask

  task automatic idle();
    bus.in_valid    = 1'b0;
    bus.in_overflow = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference flag equations: {V, N, Z, S, result[7:0]}.
  function automatic logic [11:0] model(input logic [8:0] r, input logic o);
    return {o, r[7], (r[7:0] == 8'h00), r[8], r[7:0]};
  endfunction

  initial begin
    int accepted;
    int cycles;

    bus.in_valid    = 1'b0;
    bus.in_result   = '0;
    bus.in_overflow = 1'b0;
    bus.out_ready   = 1'b1;
    clr_sticky      = 1'b0;
    rst_n           = 1'b0;

    // Reset state
    repeat (2) step();
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_out_result", 32'(bus.out_result), 0);
    check("rst_out_flags", 32'(bus.out_flags), 0);
    check("rst_sticky", 32'(sticky_ovf), 0);
    check("rst_count", 32'(ovf_count), 0);
    check("rst_state", 32'(skid_state), 32'(SK_EMPTY));
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // 1: -1 with no overflow
    drive(9'h1FF, 1'b0);
    step();
    idle();
    check("t1_valid", 32'(bus.out_valid), 1);
    check("t1_result", 32'(bus.out_result), 'hFF);
    check("t1_flags", 32'(bus.out_flags), 'b0101);
    check("t1_in_ready", 32'(bus.in_ready), 1);
    step();
    check("t1_drained", 32'(bus.out_valid), 0);
    check("t1_in_ready2", 32'(bus.in_ready), 1);

    // 2: zero result, then 127-(-1) with overflow
    drive(9'h000, 1'b0);
    step();
    idle();
    check("t2_zero_flags", 32'(bus.out_flags), 'b0010);
    check("t2_zero_result", 32'(bus.out_result), 0);
    step();
    drive(9'h080, 1'b1);
    step();
    idle();
    check("t2_ovf_flags", 32'(bus.out_flags), 'b1100);
    check("t2_ovf_result", 32'(bus.out_result), 'h80);
    check("t2_sticky", 32'(sticky_ovf), 1);
    check("t2_count", 32'(ovf_count), 1);
    step();

    // 3: back-pressure, A then B, stall, release
    bus.out_ready = 1'b0;
    drive(9'h011, 1'b0);
    step();
    check("t3_ready_after_a", 32'(bus.in_ready), 1);
    check("t3_result_a", 32'(bus.out_result), 'h11);
    drive(9'h122, 1'b0);
    step();
    check("t3_ready_after_b", 32'(bus.in_ready), 0);
    check("t3_state_full", 32'(skid_state), 32'(SK_FULL));
    drive(9'h033, 1'b1);  // ignored: in_ready is low
    for (int i = 0; i < 5; i++) begin
      step();
      check("t3_hold_result", 32'(bus.out_result), 'h11);
      check("t3_hold_flags", 32'(bus.out_flags), 'b0000);
      check("t3_hold_valid", 32'(bus.out_valid), 1);
      check("t3_hold_ready", 32'(bus.in_ready), 0);
    end
    idle();
    check("t3_ignored_ovf", 32'(ovf_count), 1);
    bus.out_ready = 1'b1;
    step();
    check("t3_result_b", 32'(bus.out_result), 'h22);
    check("t3_flags_b", 32'(bus.out_flags), 'b0001);
    check("t3_valid_b", 32'(bus.out_valid), 1);
    check("t3_ready_back", 32'(bus.in_ready), 1);
    step();
    check("t3_empty", 32'(bus.out_valid), 0);

    // 4: clear, saturation, clear colliding with an overflow accept
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    check("t4_clr_sticky", 32'(sticky_ovf), 0);
    check("t4_clr_count", 32'(ovf_count), 0);
    for (int i = 0; i < 20; i++) begin
      drive(9'h080, 1'b1);
      step();
      check("t4_sat_count", 32'(ovf_count), (i < 15) ? i + 1 : 15);
    end
    check("t4_sat_sticky", 32'(sticky_ovf), 1);
    clr_sticky = 1'b1;
    drive(9'h080, 1'b1);
    step();
    clr_sticky = 1'b0;
    idle();
    check("t4_set_wins_sticky", 32'(sticky_ovf), 1);
    check("t4_set_wins_count", 32'(ovf_count), 1);
    step();
    check("t4_drained", 32'(bus.out_valid), 0);

    // 5: reset while FULL and stalled
    bus.out_ready = 1'b0;
    drive(9'h044, 1'b0);
    step();
    drive(9'h055, 1'b1);
    step();
    idle();
    check("t5_full", 32'(skid_state), 32'(SK_FULL));
    check("t5_valid_before", 32'(bus.out_valid), 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("t5_valid_async", 32'(bus.out_valid), 0);
    check("t5_ready_async", 32'(bus.in_ready), 1);
    check("t5_sticky_async", 32'(sticky_ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t5_no_stale", 32'(bus.out_valid), 0);
    end

    // 6: random valid/ready traffic against the expected queue
    accepted = 0;
    cycles   = 0;
    while (accepted < 1000 && cycles < 20000) begin
      bus.in_valid    = 1'($urandom_range(0, 1));
      bus.out_ready   = ($urandom_range(0, 3) != 0);
      bus.in_result   = 9'($urandom_range(0, 511));
      bus.in_overflow = 1'($urandom_range(0, 1));
      #0;
      if (bus.out_valid && bus.out_ready) begin
        check("rand_q_nonempty", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0)
          check("rand_beat", 32'({bus.out_flags, bus.out_result}), 32'(exp_q.pop_front()));
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.in_result, bus.in_overflow));
        accepted++;
      end
      step();
      cycles++;
    end
    check("rand_budget", 32'(accepted), 1000);
    idle();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (bus.out_valid) begin
        check("drain_q_nonempty", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0)
          check("drain_beat", 32'({bus.out_flags, bus.out_result}), 32'(exp_q.pop_front()));
      end
      step();
    end
    check("rand_all_emitted", 32'(exp_q.size()), 0);
    check("rand_final_valid", 32'(bus.out_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
